// File: rtl/proc_isa_pkg.sv
// Shared ISA definitions for the pipelined 8-bit processor.
// Holds the opcode encodings, the register-index width and the issue-FSM
// state encodings. The issue scoreboard and instruction decoder use it,
// and the forwarding unit will too.
package proc_isa_pkg;

  localparam int REG_IDX_W = 2;
  localparam int NUM_REGS  = 4;

  // Full 4-bit opcodes in instr[3:0]
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_BPZ   = 4'b1101;

  // 3-bit patterns in instr[2:0]; instr[3] is part of the operand
  localparam logic [2:0] OP3_SHIFT = 3'b011;
  localparam logic [2:0] OP3_ORI   = 3'b111;

  // ORI always targets R1
  localparam logic [REG_IDX_W-1:0] ORI_REG = 2'd1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_HALT    = 2'd2
  } iss_state_e;

endpackage

// File: rtl/instr_class_decode.sv
// Instruction class decoder: classifies the IR1 instruction by register and
// flag usage.
// Ports:
//   i_instr        instruction byte (Rx=[7:6], Ry=[5:4], opcode=[3:0])
//   o_src_mask     one bit per register read by the instruction
//   o_writes_reg   instruction writes o_dest
//   o_dest         destination register index
//   o_writes_flags instruction updates N/Z
//   o_reads_flags  instruction consumes N/Z (conditional branches)
//   o_is_branch    conditional branch
//   o_is_stop      STOP
module instr_class_decode
  import proc_isa_pkg::*;
(
  input  logic [7:0]           i_instr,
  output logic [NUM_REGS-1:0]  o_src_mask,
  output logic                 o_writes_reg,
  output logic [REG_IDX_W-1:0] o_dest,
  output logic                 o_writes_flags,
  output logic                 o_reads_flags,
  output logic                 o_is_branch,
  output logic                 o_is_stop
);

  logic [REG_IDX_W-1:0] w_rx;
  logic [REG_IDX_W-1:0] w_ry;
  logic [NUM_REGS-1:0]  w_rx_bit;
  logic [NUM_REGS-1:0]  w_ry_bit;

  assign w_rx     = i_instr[7:6];
  assign w_ry     = i_instr[5:4];
  assign w_rx_bit = 4'b0001 << w_rx;
  assign w_ry_bit = 4'b0001 << w_ry;

  always_comb begin
    o_src_mask     = '0;
    o_writes_reg   = 1'b0;
    o_dest         = w_rx;
    o_writes_flags = 1'b0;
    o_reads_flags  = 1'b0;
    o_is_branch    = 1'b0;
    o_is_stop      = 1'b0;
    // SHIFT and ORI are matched on 3 bits first; their patterns do not
    // collide with any of the full 4-bit opcodes.
    if (i_instr[2:0] == OP3_SHIFT) begin
      o_src_mask     = w_rx_bit;
      o_writes_reg   = 1'b1;
      o_writes_flags = 1'b1;
    end else if (i_instr[2:0] == OP3_ORI) begin
      o_src_mask     = 4'b0001 << ORI_REG;
      o_writes_reg   = 1'b1;
      o_dest         = ORI_REG;
      o_writes_flags = 1'b1;
    end else begin
      case (i_instr[3:0])
        OP_LOAD: begin
          o_src_mask   = w_ry_bit;
          o_writes_reg = 1'b1;
        end
        OP_STORE: o_src_mask = w_rx_bit | w_ry_bit;
        OP_ADD, OP_SUB, OP_NAND: begin
          o_src_mask     = w_rx_bit | w_ry_bit;
          o_writes_reg   = 1'b1;
          o_writes_flags = 1'b1;
        end
        OP_BZ, OP_BNZ, OP_BPZ: begin
          o_reads_flags = 1'b1;
          o_is_branch   = 1'b1;
        end
        OP_STOP: o_is_stop = 1'b1;
        default: ;  // unassigned encodings behave as hazard-free NOPs
      endcase
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard controller. Decides each cycle whether IR1 may issue,
// using per-register and flag pending-write countdowns, holds issue while a
// branch resolves, pulses flush on a taken branch and latches halt on STOP.
// Ports:
//   clock, reset                 clock; async active-high reset
//   i_instr_valid, i_instr       IR1 contents
//   i_br_resolved, i_br_taken    branch outcome pulse from execute
//   o_issue, o_stall, o_flush    per-cycle issue decision
//   o_halted                     sticky after STOP issues
//   o_busy_mask, o_flags_busy    pending writes
//   o_stall_count                saturating count of stall cycles
//
// state   | meaning
// RUN     | normal issue, hazards checked against the countdowns
// BR_WAIT | branch issued, holding until execute resolves it
// HALT    | STOP issued, nothing issues until reset
module issue_scoreboard
  import proc_isa_pkg::*;
#(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_instr_valid,
  input  logic [7:0]          i_instr,
  input  logic                i_br_resolved,
  input  logic                i_br_taken,
  output logic                o_issue,
  output logic                o_stall,
  output logic                o_flush,
  output logic                o_halted,
  output logic [NUM_REGS-1:0] o_busy_mask,
  output logic                o_flags_busy,
  output logic [CNT_W-1:0]    o_stall_count
);

  localparam int CW = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(WB_LAT);

  logic [NUM_REGS-1:0]  w_src_mask;
  logic                 w_writes_reg;
  logic [REG_IDX_W-1:0] w_dest;
  logic                 w_writes_flags;
  logic                 w_reads_flags;
  logic                 w_is_branch;
  logic                 w_is_stop;

  instr_class_decode u_decode (
    .i_instr       (i_instr),
    .o_src_mask    (w_src_mask),
    .o_writes_reg  (w_writes_reg),
    .o_dest        (w_dest),
    .o_writes_flags(w_writes_flags),
    .o_reads_flags (w_reads_flags),
    .o_is_branch   (w_is_branch),
    .o_is_stop     (w_is_stop)
  );

  iss_state_e          r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt [NUM_REGS];
  logic [CW-1:0]       r_fcnt;
  logic [CNT_W-1:0]    r_stall_count;
  logic [NUM_REGS-1:0] w_busy;
  logic                w_fbusy;
  logic                w_hazard;
  logic                w_issue, w_stall, w_flush, w_halted;

  always_comb begin
    w_busy = '0;
    for (int r = 0; r < NUM_REGS; r++) w_busy[r] = (r_cnt[r] != '0);
  end
  assign w_fbusy  = (r_fcnt != '0);
  assign w_hazard = i_instr_valid &
                    (((w_src_mask & w_busy) != '0) | (w_reads_flags & w_fbusy));

  // Countdowns: an issuing writer re-arms to WB_LAT, which takes priority
  // over the decrement so back-to-back writers to one register stay correct.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_fcnt <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_issue && w_writes_reg && (w_dest == REG_IDX_W'(r)))
          r_cnt[r] <= LAT;
        else if (r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - CW'(1);
      end
      if (w_issue && w_writes_flags) r_fcnt <= LAT;
      else if (r_fcnt != '0)         r_fcnt <= r_fcnt - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_issue && w_is_branch)    w_state_nxt = ST_BR_WAIT;
        else if (w_issue && w_is_stop) w_state_nxt = ST_HALT;
      end
      ST_BR_WAIT: if (i_br_resolved) w_state_nxt = ST_RUN;
      ST_HALT:    w_state_nxt = ST_HALT;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs are forced low while reset is held so nothing downstream sees
  // an issue or stall before the state register has settled.
  always_comb begin
    w_issue  = 1'b0;
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_issue = i_instr_valid & ~w_hazard;
        w_stall = w_hazard;
      end
      ST_BR_WAIT: begin
        w_stall = i_instr_valid;
        w_flush = i_br_resolved & i_br_taken;
      end
      ST_HALT: w_halted = 1'b1;
      default: ;
    endcase
    if (reset) begin
      w_issue  = 1'b0;
      w_stall  = 1'b0;
      w_flush  = 1'b0;
      w_halted = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_stall_count <= '0;
    else if (w_stall && (r_stall_count != '1))
      r_stall_count <= r_stall_count + CNT_W'(1);
  end

  assign o_issue       = w_issue;
  assign o_stall       = w_stall;
  assign o_flush       = w_flush;
  assign o_halted      = w_halted;
  assign o_busy_mask   = w_busy;
  assign o_flags_busy  = w_fbusy;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       br_resolved = 1'b0;
  logic       br_taken = 1'b0;

  // main instance: WB_LAT=3, CNT_W=16
  logic        issue0, stall0, flush0, halted0, fbusy0;
  logic [3:0]  busy0;
  logic [15:0] sc0;
  // second instance: WB_LAT=1, CNT_W=3 for short latency and saturation
  logic        issue1, stall1, flush1, halted1, fbusy1;
  logic [3:0]  busy1;
  logic [2:0]  sc1;

  int n_chk  = 0;
  int n_fail = 0;

  issue_scoreboard #(.WB_LAT(3), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .i_instr_valid(instr_valid), .i_instr(instr),
    .i_br_resolved(br_resolved), .i_br_taken(br_taken),
    .o_issue(issue0), .o_stall(stall0), .o_flush(flush0), .o_halted(halted0),
    .o_busy_mask(busy0), .o_flags_busy(fbusy0), .o_stall_count(sc0));

  issue_scoreboard #(.WB_LAT(1), .CNT_W(3)) dut1 (
    .clock(clock), .reset(reset), .i_instr_valid(instr_valid), .i_instr(instr),
    .i_br_resolved(br_resolved), .i_br_taken(br_taken),
    .o_issue(issue1), .o_stall(stall1), .o_flush(flush1), .o_halted(halted1),
    .o_busy_mask(busy1), .o_flags_busy(fbusy1), .o_stall_count(sc1));

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, vld;
    logic [7:0]  ins;
    logic        br, tk;
    logic        iss, stl, fl, hlt;
    logic [3:0]  bm;
    logic        fb;
    logic [15:0] sc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, vld, input logic [7:0] ins,
                              input logic br, tk, iss, stl, fl, hlt,
                              input logic [3:0] bm, input logic fb,
                              input logic [15:0] sc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ins = ins; v.br = br; v.tk = tk;
    v.iss = iss; v.stl = stl; v.fl = fl; v.hlt = hlt; v.bm = bm; v.fb = fb; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, vld, input logic [7:0] ins, input logic br, tk);
    @(negedge clock);
    reset = rst; instr_valid = vld; instr = ins; br_resolved = br; br_taken = tk;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // rst vld ins  br tk | iss stl fl hlt bm fb sc
    // RAW on R1: ADD R1,R2 then ADD R0,R1 -> 3 stalls
    vecs.push_back(mk(1,1,8'h64,0,0, 0,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h64,0,0, 1,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h14,0,0, 0,1,0,0,4'h2,1,0));
    vecs.push_back(mk(0,1,8'h14,0,0, 0,1,0,0,4'h2,1,1));
    vecs.push_back(mk(0,1,8'h14,0,0, 0,1,0,0,4'h2,1,2));
    vecs.push_back(mk(0,1,8'h14,0,0, 1,0,0,0,4'h0,0,3));
    // LOAD R2,(R3) then STORE R0,(R1): no hazard
    vecs.push_back(mk(1,1,8'h64,0,0, 0,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'hB0,0,0, 1,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h12,0,0, 1,0,0,0,4'h4,0,0));
    vecs.push_back(mk(0,0,8'h12,0,0, 0,0,0,0,4'h4,0,0));
    // ORI then SHIFT R1
    vecs.push_back(mk(1,1,8'h0F,0,0, 0,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h0F,0,0, 1,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h43,0,0, 0,1,0,0,4'h2,1,0));
    vecs.push_back(mk(0,1,8'h43,0,0, 0,1,0,0,4'h2,1,1));
    vecs.push_back(mk(0,1,8'h43,0,0, 0,1,0,0,4'h2,1,2));
    vecs.push_back(mk(0,1,8'h43,0,0, 1,0,0,0,4'h0,0,3));
    // flags hazard, BZ, taken branch
    vecs.push_back(mk(1,1,8'h64,0,0, 0,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h64,0,0, 1,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h05,0,0, 0,1,0,0,4'h2,1,0));
    vecs.push_back(mk(0,1,8'h05,0,0, 0,1,0,0,4'h2,1,1));
    vecs.push_back(mk(0,1,8'h05,0,0, 0,1,0,0,4'h2,1,2));
    vecs.push_back(mk(0,1,8'h05,0,0, 1,0,0,0,4'h0,0,3));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,1,8'h14,0,0, 0,1,0,0,4'h0,0,16'(3+k)));
    vecs.push_back(mk(0,1,8'h14,1,1, 0,1,1,0,4'h0,0,8));
    vecs.push_back(mk(0,1,8'h14,0,0, 1,0,0,0,4'h0,0,9));
    // drain, then not-taken branch with instr_valid=0 while resolving
    vecs.push_back(mk(0,0,8'h00,0,0, 0,0,0,0,4'h1,1,9));
    vecs.push_back(mk(0,0,8'h00,0,0, 0,0,0,0,4'h1,1,9));
    vecs.push_back(mk(0,0,8'h00,0,0, 0,0,0,0,4'h1,1,9));
    vecs.push_back(mk(0,1,8'h05,0,0, 1,0,0,0,4'h0,0,9));
    vecs.push_back(mk(0,0,8'h00,1,0, 0,0,0,0,4'h0,0,9));
    vecs.push_back(mk(0,1,8'h12,1,1, 1,0,0,0,4'h0,0,9));
    // STOP and halt
    vecs.push_back(mk(1,0,8'h00,0,0, 0,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h01,0,0, 1,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h14,0,0, 0,0,0,1,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h14,1,1, 0,0,0,1,4'h0,0,0));
    vecs.push_back(mk(1,1,8'h14,0,0, 0,0,0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,8'h14,0,0, 1,0,0,0,4'h0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].ins, vecs[i].br, vecs[i].tk);
      chk($sformatf("row%0d.issue", i),  16'(issue0),  16'(vecs[i].iss));
      chk($sformatf("row%0d.stall", i),  16'(stall0),  16'(vecs[i].stl));
      chk($sformatf("row%0d.flush", i),  16'(flush0),  16'(vecs[i].fl));
      chk($sformatf("row%0d.halted", i), 16'(halted0), 16'(vecs[i].hlt));
      chk($sformatf("row%0d.busy", i),   16'(busy0),   16'(vecs[i].bm));
      chk($sformatf("row%0d.fbusy", i),  16'(fbusy0),  16'(vecs[i].fb));
      chk($sformatf("row%0d.scount", i), sc0,          vecs[i].sc);
    end

    // WB_LAT=1 instance: ORI then SHIFT gives one stall; then saturation of a 3-bit count
    drive(1,0,8'h00,0,0);
    drive(0,1,8'h0F,0,0);
    chk("lat1.ori_issue", 16'(issue1), 16'd1);
    drive(0,1,8'h43,0,0);
    chk("lat1.shift_stall", 16'(stall1), 16'd1);
    chk("lat1.shift_busy", 16'(busy1), 16'h2);
    drive(0,1,8'h43,0,0);
    chk("lat1.shift_issue", 16'(issue1), 16'd1);
    chk("lat1.scount1", 16'(sc1), 16'd1);
    drive(0,1,8'h05,0,0);
    chk("lat1.bz_stall", 16'(stall1), 16'd1);
    drive(0,1,8'h05,0,0);
    chk("lat1.bz_issue", 16'(issue1), 16'd1);
    chk("lat1.scount2", 16'(sc1), 16'd2);
    for (int k = 0; k < 8; k++) drive(0,1,8'h14,0,0);
    chk("lat1.sat_scount", 16'(sc1), 16'd7);
    chk("lat1.brwait_stall", 16'(stall1), 16'd1);
    chk("lat1.brwait_flush", 16'(flush1), 16'd0);
    chk("lat1.halted", 16'(halted1), 16'd0);
    chk("lat1.fbusy", 16'(fbusy1), 16'd0);

    // Asynchronous reset in the middle of BR_WAIT with cnt[1]=2
    drive(1,0,8'h00,0,0);
    drive(0,1,8'h64,0,0);
    chk("mid.add_issue", 16'(issue0), 16'd1);
    drive(0,1,8'h05,0,0);
    drive(0,1,8'h05,0,0);
    drive(0,1,8'h05,0,0);
    drive(0,1,8'h05,0,0);
    chk("mid.bz_issue", 16'(issue0), 16'd1);
    drive(0,0,8'h00,1,0);
    chk("mid.nt_flush", 16'(flush0), 16'd0);
    drive(0,1,8'h60,0,0);
    chk("mid.load_issue", 16'(issue0), 16'd1);
    drive(0,1,8'h05,0,0);
    chk("mid.bz2_issue", 16'(issue0), 16'd1);
    drive(0,1,8'h14,0,0);
    chk("mid.pre_stall", 16'(stall0), 16'd1);
    chk("mid.pre_busy", 16'(busy0), 16'h2);
    chk("mid.pre_scount", sc0, 16'd3);
    #2 reset = 1'b1;
    #1;
    chk("mid.rst_busy", 16'(busy0), 16'h0);
    chk("mid.rst_stall", 16'(stall0), 16'd0);
    chk("mid.rst_issue", 16'(issue0), 16'd0);
    chk("mid.rst_scount", sc0, 16'd0);
    chk("mid.rst_halted", 16'(halted0), 16'd0);
    drive(0,1,8'h14,0,0);
    chk("mid.post_issue", 16'(issue0), 16'd1);
    chk("mid.post_stall", 16'(stall0), 16'd0);
    chk("mid.post_busy", 16'(busy0), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
